// File: rtl/probatina_axi_mem_pkg.sv
// rtl/probatina_axi_mem_pkg.sv - shared types and geometry helpers for the AXI memory responder
package probatina_axi_mem_pkg;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

   // Bytes carried by one data word
   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   // Byte-offset bits dropped when turning a byte address into a word index
   function automatic int word_shift(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   // Width of the physical RAM index
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/probatina_axi_mem_ram.sv
// rtl/probatina_axi_mem_ram.sv - byte-enable write, asynchronous read word memory
module probatina_axi_mem_ram
   import probatina_axi_mem_pkg::*;
#(
   parameter int C_WIDTH     = 512,
   parameter int C_DEPTH     = 1024,
   parameter int C_IDX_WIDTH = idx_width(1024),
   parameter int C_BYTES     = C_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [C_IDX_WIDTH-1:0] waddr,
   input  logic [C_WIDTH-1:0]     wdata,
   input  logic [C_BYTES-1:0]     wstrb,
   input  logic [C_IDX_WIDTH-1:0] raddr,
   output logic [C_WIDTH-1:0]     rdata
);

   logic [C_WIDTH-1:0] mem [C_DEPTH];

   // Write only the byte lanes whose strobe bit is set; contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < C_BYTES; b++) begin
            if (wstrb[b]) begin
               mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/probatina_axi_mem_slave.sv
// rtl/probatina_axi_mem_slave.sv - AXI4 memory responder for the probatina m00_axi master port
module probatina_axi_mem_slave
   import probatina_axi_mem_pkg::*;
#(
   parameter int              C_S_AXI_ADDR_WIDTH = 64,
   parameter int              C_S_AXI_DATA_WIDTH = 512,
   parameter int              C_MEM_DEPTH        = 1024,
   parameter longint unsigned C_BASE_ADDR        = 0
) (
   input  logic                              ap_clk,
   input  logic                              areset,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                        s_axi_awlen,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wlast,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                        s_axi_arlen,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic                              s_axi_rlast,
   output logic                              err_wlast,
   output logic                              err_range
);

   localparam int LP_BYTES_PER_WORD = bytes_per_word(C_S_AXI_DATA_WIDTH);
   localparam int LP_WORD_SHIFT     = word_shift(C_S_AXI_DATA_WIDTH);
   localparam int LP_IDX_WIDTH      = idx_width(C_MEM_DEPTH);
   localparam int AW                = C_S_AXI_ADDR_WIDTH;
   localparam int DW                = C_S_AXI_DATA_WIDTH;

   localparam logic [AW-1:0] LP_BASE  = AW'(C_BASE_ADDR);
   localparam logic [AW-1:0] LP_DEPTH = AW'(C_MEM_DEPTH);

   // Full-width word index; addresses below the base wrap high and read as out of range
   function automatic logic [AW-1:0] to_index(input logic [AW-1:0] addr);
      return (addr - LP_BASE) >> LP_WORD_SHIFT;
   endfunction

   logic            rst_meta;
   logic            rst;

   wr_state_t       w_state;
   logic [AW-1:0]   w_idx;
   logic [8:0]      w_cnt;
   rd_state_t       r_state;
   logic [AW-1:0]   r_idx;
   logic [7:0]      r_rem;

   logic            aw_fire;
   logic            w_fire;
   logic            ar_fire;
   logic            r_fire;
   logic            rd_load;
   logic [AW-1:0]   rd_idx;
   logic            rd_in_range;
   logic            wr_in_range;
   logic [DW-1:0]   ram_rdata;
   logic [DW-1:0]   rd_word;

   assign aw_fire     = s_axi_awvalid && s_axi_awready;
   assign w_fire      = s_axi_wvalid && s_axi_wready;
   assign ar_fire     = s_axi_arvalid && s_axi_arready;
   assign r_fire      = s_axi_rvalid && s_axi_rready;
   assign rd_load     = ar_fire || (r_fire && !s_axi_rlast);
   assign rd_idx      = (r_state == R_IDLE) ? to_index(s_axi_araddr) : r_idx;
   assign rd_in_range = rd_idx < LP_DEPTH;
   assign wr_in_range = w_idx < LP_DEPTH;
   assign rd_word     = rd_in_range ? ram_rdata : '0;

   // Reset asserts immediately and releases two clocks after areset drops
   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         rst_meta <= 1'b1;
         rst      <= 1'b1;
      end else begin
         rst_meta <= 1'b0;
         rst      <= rst_meta;
      end
   end

   probatina_axi_mem_ram #(
      .C_WIDTH     (DW),
      .C_DEPTH     (C_MEM_DEPTH),
      .C_IDX_WIDTH (LP_IDX_WIDTH),
      .C_BYTES     (LP_BYTES_PER_WORD)
   ) u_ram (
      .clk   (ap_clk),
      .we    (w_fire && wr_in_range),
      .waddr (w_idx[LP_IDX_WIDTH-1:0]),
      .wdata (s_axi_wdata),
      .wstrb (s_axi_wstrb),
      .raddr (rd_idx[LP_IDX_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   // Write burst FSM: accept address, count beats, then hold one B response
   always_ff @(posedge ap_clk or posedge rst) begin
      if (rst) begin
         w_state       <= W_IDLE;
         w_idx         <= '0;
         w_cnt         <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         err_wlast     <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_fire) begin
                  w_idx         <= to_index(s_axi_awaddr);
                  w_cnt         <= {1'b0, s_axi_awlen} + 9'd1;
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  w_state       <= W_DATA;
               end else begin
                  s_axi_awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  if (s_axi_wlast != (w_cnt == 9'd1)) begin
                     err_wlast <= 1'b1;
                  end
                  w_idx <= w_idx + 1'b1;
                  w_cnt <= w_cnt - 9'd1;
                  if (w_cnt == 9'd1) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     w_state      <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read burst FSM: one registered beat per cycle, stalled data held in place
   always_ff @(posedge ap_clk or posedge rst) begin
      if (rst) begin
         r_state       <= R_IDLE;
         r_idx         <= '0;
         r_rem         <= '0;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rdata   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_fire) begin
                  s_axi_rdata   <= rd_word;
                  r_idx         <= rd_idx + 1'b1;
                  r_rem         <= s_axi_arlen;
                  s_axi_rlast   <= (s_axi_arlen == 8'd0);
                  s_axi_rvalid  <= 1'b1;
                  s_axi_arready <= 1'b0;
                  r_state       <= R_DATA;
               end else begin
                  s_axi_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (r_fire) begin
                  if (s_axi_rlast) begin
                     s_axi_rvalid  <= 1'b0;
                     s_axi_rlast   <= 1'b0;
                     s_axi_arready <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     s_axi_rdata <= rd_word;
                     r_idx       <= r_idx + 1'b1;
                     r_rem       <= r_rem - 8'd1;
                     s_axi_rlast <= (r_rem == 8'd1);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Sticky range error from either a dropped write beat or a zero-filled read beat
   always_ff @(posedge ap_clk or posedge rst) begin
      if (rst) begin
         err_range <= 1'b0;
      end else if ((w_fire && !wr_in_range) || (rd_load && !rd_in_range)) begin
         err_range <= 1'b1;
      end
   end

endmodule

// File: tb/tb_probatina_axi_mem_slave.sv
// tb/tb_probatina_axi_mem_slave.sv - randomized self-checking bench for probatina_axi_mem_slave
module tb_probatina_axi_mem_slave;

   localparam int          AW    = 64;
   localparam int          DW    = 512;
   localparam int          NB    = DW / 8;
   localparam int          DEPTH = 64;
   localparam logic [63:0] BASE  = 64'h1000;

   logic          ap_clk = 1'b0;
   logic          areset = 1'b1;
   logic          s_axi_awvalid = 1'b0;
   logic          s_axi_awready;
   logic [AW-1:0] s_axi_awaddr = '0;
   logic [7:0]    s_axi_awlen = '0;
   logic          s_axi_wvalid = 1'b0;
   logic          s_axi_wready;
   logic [DW-1:0] s_axi_wdata = '0;
   logic [NB-1:0] s_axi_wstrb = '0;
   logic          s_axi_wlast = 1'b0;
   logic          s_axi_bvalid;
   logic          s_axi_bready = 1'b0;
   logic          s_axi_arvalid = 1'b0;
   logic          s_axi_arready;
   logic [AW-1:0] s_axi_araddr = '0;
   logic [7:0]    s_axi_arlen = '0;
   logic          s_axi_rvalid;
   logic          s_axi_rready = 1'b0;
   logic [DW-1:0] s_axi_rdata;
   logic          s_axi_rlast;
   logic          err_wlast;
   logic          err_range;

   int compared = 0;
   int mismatched = 0;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] wd_q [$];
   logic [NB-1:0] ws_q [$];
   logic [DW-1:0] rd_q [$];
   logic          rl_q [$];

   always #5 ap_clk = ~ap_clk;

   probatina_axi_mem_slave #(
      .C_S_AXI_ADDR_WIDTH (AW),
      .C_S_AXI_DATA_WIDTH (DW),
      .C_MEM_DEPTH        (DEPTH),
      .C_BASE_ADDR        (BASE)
   ) dut (
      .ap_clk        (ap_clk),
      .areset        (areset),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awlen   (s_axi_awlen),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wlast   (s_axi_wlast),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arlen   (s_axi_arlen),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rlast   (s_axi_rlast),
      .err_wlast     (err_wlast),
      .err_range     (err_range)
   );

   function automatic logic [63:0] addr_of(input int idx);
      return BASE + 64'(idx) * 64'(NB);
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   // Memory view a read of word idx must return: stored word, or zeros outside memory
   function automatic logic [DW-1:0] exp_word(input logic [63:0] idx);
      if (idx < 64'(DEPTH)) return model[idx[5:0]];
      return '0;
   endfunction

   // Write burst from wd_q/ws_q; bad_last >= 0 puts wlast on that beat only
   task automatic do_write(input logic [63:0] addr, input int len, input int bad_last,
                           output int bcnt, output logic b_timely);
      int t;
      logic [63:0] ix;
      @(negedge ap_clk);
      s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
      t = 0;
      while (!s_axi_awready && t < 50) begin @(negedge ap_clk); t++; end
      compared++;
      if (t >= 50) begin mismatched++; $display("FAIL aw_timeout: awready=%b required 1", s_axi_awready); end
      @(negedge ap_clk);
      s_axi_awvalid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         if ($urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; @(negedge ap_clk); end
         s_axi_wvalid = 1'b1; s_axi_wdata = wd_q[b]; s_axi_wstrb = ws_q[b];
         s_axi_wlast = (bad_last >= 0) ? (b == bad_last) : (b == len);
         t = 0;
         while (!s_axi_wready && t < 50) begin @(negedge ap_clk); t++; end
         if (t >= 50) begin
            compared++; mismatched++;
            $display("FAIL w_timeout: wready=%b required 1", s_axi_wready);
         end
         ix = ((addr - BASE) >> $clog2(NB)) + 64'(b);
         if (ix < 64'(DEPTH))
            for (int j = 0; j < NB; j++)
               if (ws_q[b][j]) model[ix[5:0]][j*8 +: 8] = wd_q[b][j*8 +: 8];
         @(negedge ap_clk);
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      b_timely = s_axi_bvalid;
      bcnt = 0;
      for (int k = 0; k < 8; k++) begin
         s_axi_bready = (k >= 1);
         if (s_axi_bvalid && s_axi_bready) bcnt++;
         @(negedge ap_clk);
      end
      s_axi_bready = 1'b0;
   endtask

   // Read burst into rd_q/rl_q; mode 0 rready high, 1 pattern 1,0,0,1, 2 random
   task automatic do_read(input logic [63:0] addr, input int len, input int mode,
                          output logic lat_ok, output int unstable);
      int t, k;
      logic prev_stall;
      logic [DW-1:0] prev_data;
      logic prev_last;
      rd_q.delete(); rl_q.delete();
      unstable = 0;
      @(negedge ap_clk);
      s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = 8'(len);
      t = 0;
      while (!s_axi_arready && t < 50) begin @(negedge ap_clk); t++; end
      compared++;
      if (t >= 50) begin mismatched++; $display("FAIL ar_timeout: arready=%b required 1", s_axi_arready); end
      @(negedge ap_clk);
      s_axi_arvalid = 1'b0;
      lat_ok = s_axi_rvalid;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      k = 0; t = 0;
      while (rd_q.size() < len + 1 && t < 3000) begin
         case (mode)
            0:       s_axi_rready = 1'b1;
            1:       s_axi_rready = (k % 4 == 0) || (k % 4 == 3);
            default: s_axi_rready = 1'($urandom_range(0, 1));
         endcase
         if (prev_stall && (s_axi_rdata !== prev_data || s_axi_rlast !== prev_last || !s_axi_rvalid))
            unstable++;
         if (s_axi_rvalid && s_axi_rready) begin
            rd_q.push_back(s_axi_rdata); rl_q.push_back(s_axi_rlast);
         end
         prev_stall = s_axi_rvalid && !s_axi_rready;
         prev_data = s_axi_rdata; prev_last = s_axi_rlast;
         k++; t++;
         @(negedge ap_clk);
      end
      s_axi_rready = 1'b0;
      if (t >= 3000) begin
         compared++; mismatched++;
         $display("FAIL r_timeout: beats=%0d required %0d", rd_q.size(), len + 1);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge ap_clk);
      compared++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
           err_wlast, err_range} !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_flags: got %b required 00000000", {s_axi_awready, s_axi_wready,
                  s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, err_wlast, err_range});
      end
      compared++;
      if (s_axi_rdata !== '0) begin mismatched++; $display("FAIL reset_rdata: got %h required 0", s_axi_rdata); end
      areset = 1'b0;
      repeat (5) @(negedge ap_clk);
      compared++;
      if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
         mismatched++; $display("FAIL idle_ready: got %b required 11", {s_axi_awready, s_axi_arready});
      end
   endtask

   task automatic test_fill();
      int bcnt; logic bt;
      for (int r = 0; r < DEPTH / 16; r++) begin
         wd_q.delete(); ws_q.delete();
         for (int b = 0; b < 16; b++) begin wd_q.push_back(rand_word()); ws_q.push_back('1); end
         do_write(addr_of(r * 16), 15, -1, bcnt, bt);
         compared++;
         if (bcnt !== 1) begin mismatched++; $display("FAIL fill_bcount: got %0d required 1", bcnt); end
      end
   endtask

   task automatic test_basic_burst();
      int bcnt, unstable; logic bt, lat;
      logic [DW-1:0] pat;
      wd_q.delete(); ws_q.delete();
      for (int b = 0; b < 4; b++) begin
         pat = {NB{8'(8'h11 * (b + 1))}};
         wd_q.push_back(pat); ws_q.push_back('1);
      end
      do_write(BASE, 3, -1, bcnt, bt);
      compared++;
      if (bcnt !== 1) begin mismatched++; $display("FAIL basic_bcount: got %0d required 1", bcnt); end
      compared++;
      if (bt !== 1'b1) begin mismatched++; $display("FAIL basic_b_timing: bvalid=%b required 1", bt); end
      do_read(BASE, 3, 0, lat, unstable);
      compared++;
      if (lat !== 1'b1) begin mismatched++; $display("FAIL basic_latency: rvalid=%b required 1", lat); end
      for (int b = 0; b < 4; b++) begin
         pat = {NB{8'(8'h11 * (b + 1))}};
         compared++;
         if (b >= rd_q.size() || rd_q[b] !== pat) begin
            mismatched++; $display("FAIL basic_data[%0d]: got %h required %h", b, (b < rd_q.size()) ? rd_q[b] : '0, pat);
         end
         compared++;
         if (b >= rl_q.size() || rl_q[b] !== (b == 3)) begin
            mismatched++; $display("FAIL basic_rlast[%0d]: got %b required %b", b, (b < rl_q.size()) ? rl_q[b] : 1'bx, b == 3);
         end
      end
      compared++;
      if (s_axi_rvalid !== 1'b0) begin mismatched++; $display("FAIL basic_rvalid_end: got %b required 0", s_axi_rvalid); end
   endtask

   task automatic test_partial_strobe();
      int bcnt, unstable; logic bt, lat;
      logic [DW-1:0] want;
      wd_q = '{{NB{8'hFF}}}; ws_q = '{'1};
      do_write(addr_of(5), 0, -1, bcnt, bt);
      wd_q = '{'0}; ws_q = '{NB'(1)};
      do_write(addr_of(5), 0, -1, bcnt, bt);
      want = {{(NB - 1){8'hFF}}, 8'h00};
      do_read(addr_of(5), 0, 0, lat, unstable);
      compared++;
      if (rd_q.size() < 1 || rd_q[0] !== want) begin
         mismatched++; $display("FAIL partial_strobe: got %h required %h", (rd_q.size() > 0) ? rd_q[0] : '0, want);
      end
   endtask

   task automatic test_rready_toggle();
      int bcnt, unstable; logic bt, lat;
      wd_q.delete(); ws_q.delete();
      for (int b = 0; b < 8; b++) begin wd_q.push_back(rand_word()); ws_q.push_back('1); end
      do_write(addr_of(8), 7, -1, bcnt, bt);
      do_read(addr_of(8), 7, 1, lat, unstable);
      compared++;
      if (rd_q.size() !== 8) begin mismatched++; $display("FAIL toggle_count: got %0d required 8", rd_q.size()); end
      compared++;
      if (unstable !== 0) begin mismatched++; $display("FAIL toggle_stable: unstable=%0d required 0", unstable); end
      for (int b = 0; b < rd_q.size(); b++) begin
         compared++;
         if (rd_q[b] !== exp_word(64'(8 + b))) begin
            mismatched++; $display("FAIL toggle_data[%0d]: got %h required %h", b, rd_q[b], exp_word(64'(8 + b)));
         end
      end
   endtask

   task automatic test_wlast_err();
      int bcnt, unstable; logic bt, lat;
      compared++;
      if (err_wlast !== 1'b0) begin mismatched++; $display("FAIL wlast_pre: got %b required 0", err_wlast); end
      wd_q = '{rand_word(), rand_word()}; ws_q = '{'1, '1};
      do_write(addr_of(20), 1, 0, bcnt, bt);
      compared++;
      if (err_wlast !== 1'b1) begin mismatched++; $display("FAIL wlast_flag: got %b required 1", err_wlast); end
      compared++;
      if (bcnt !== 1) begin mismatched++; $display("FAIL wlast_bcount: got %0d required 1", bcnt); end
      do_read(addr_of(20), 1, 0, lat, unstable);
      for (int b = 0; b < 2; b++) begin
         compared++;
         if (b >= rd_q.size() || rd_q[b] !== exp_word(64'(20 + b))) begin
            mismatched++; $display("FAIL wlast_data[%0d]: got %h required %h", b, (b < rd_q.size()) ? rd_q[b] : '0, exp_word(64'(20 + b)));
         end
      end
   endtask

   task automatic test_range();
      int bcnt, unstable; logic bt, lat;
      compared++;
      if (err_range !== 1'b0) begin mismatched++; $display("FAIL range_pre: got %b required 0", err_range); end
      do_read(addr_of(DEPTH), 0, 0, lat, unstable);
      compared++;
      if (rd_q.size() < 1 || rd_q[0] !== '0) begin
         mismatched++; $display("FAIL range_read: got %h required 0", (rd_q.size() > 0) ? rd_q[0] : '1);
      end
      compared++;
      if (err_range !== 1'b1) begin mismatched++; $display("FAIL range_flag: got %b required 1", err_range); end
      wd_q = '{rand_word()}; ws_q = '{'1};
      do_write(addr_of(DEPTH), 0, -1, bcnt, bt);
      wd_q = '{rand_word(), rand_word()}; ws_q = '{'1, '1};
      do_write(addr_of(DEPTH - 1), 1, -1, bcnt, bt);
      do_read(addr_of(DEPTH - 2), 3, 2, lat, unstable);
      for (int b = 0; b < 4; b++) begin
         compared++;
         if (b >= rd_q.size() || rd_q[b] !== exp_word(64'(DEPTH - 2 + b))) begin
            mismatched++; $display("FAIL range_edge[%0d]: got %h required %h", b, (b < rd_q.size()) ? rd_q[b] : '1, exp_word(64'(DEPTH - 2 + b)));
         end
      end
      do_read(addr_of(0), 0, 0, lat, unstable);
      compared++;
      if (rd_q.size() < 1 || rd_q[0] !== exp_word(0)) begin
         mismatched++; $display("FAIL range_alias: got %h required %h", (rd_q.size() > 0) ? rd_q[0] : '0, exp_word(0));
      end
   endtask

   task automatic test_random();
      int bcnt, unstable, idx, len, lim; logic bt, lat;
      logic [63:0] wa, ra;
      for (int it = 0; it < 6; it++) begin
         idx = $urandom_range(0, DEPTH - 4);
         lim = (DEPTH - 1 - idx > 15) ? 15 : DEPTH - 1 - idx;
         len = $urandom_range(0, lim);
         wa = addr_of(idx) + 64'($urandom_range(0, NB - 1));
         ra = addr_of(idx) + 64'($urandom_range(0, NB - 1));
         wd_q.delete(); ws_q.delete();
         for (int b = 0; b <= len; b++) begin
            wd_q.push_back(rand_word());
            ws_q.push_back({$urandom(), $urandom()});
         end
         do_write(wa, len, -1, bcnt, bt);
         compared++;
         if (bcnt !== 1) begin mismatched++; $display("FAIL rand_bcount[%0d]: got %0d required 1", it, bcnt); end
         do_read(ra, len, 2, lat, unstable);
         compared++;
         if (unstable !== 0) begin mismatched++; $display("FAIL rand_stable[%0d]: unstable=%0d required 0", it, unstable); end
         for (int b = 0; b < rd_q.size(); b++) begin
            compared++;
            if (rd_q[b] !== exp_word(64'(idx + b)) || rl_q[b] !== (b == len)) begin
               mismatched++; $display("FAIL rand_data[%0d.%0d]: got %h/%b required %h/%b", it, b, rd_q[b], rl_q[b], exp_word(64'(idx + b)), b == len);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int bcnt, unstable; logic bt, lat;
      logic [DW-1:0] exp_q [$];
      for (int b = 0; b < 8; b++) exp_q.push_back(exp_word(64'(24 + b)));
      wd_q.delete(); ws_q.delete();
      for (int b = 0; b < 8; b++) begin wd_q.push_back(rand_word()); ws_q.push_back('1); end
      fork
         do_write(addr_of(40), 7, -1, bcnt, bt);
         do_read(addr_of(24), 7, 0, lat, unstable);
      join
      for (int b = 0; b < 8; b++) begin
         compared++;
         if (b >= rd_q.size() || rd_q[b] !== exp_q[b]) begin
            mismatched++; $display("FAIL concurrent_read[%0d]: got %h required %h", b, (b < rd_q.size()) ? rd_q[b] : '0, exp_q[b]);
         end
      end
      do_read(addr_of(40), 7, 0, lat, unstable);
      for (int b = 0; b < 8; b++) begin
         compared++;
         if (b >= rd_q.size() || rd_q[b] !== exp_word(64'(40 + b))) begin
            mismatched++; $display("FAIL concurrent_write[%0d]: got %h required %h", b, (b < rd_q.size()) ? rd_q[b] : '0, exp_word(64'(40 + b)));
         end
      end
   endtask

   task automatic test_reset_midburst();
      int t, spurious, unstable; logic lat;
      @(negedge ap_clk);
      s_axi_arvalid = 1'b1; s_axi_araddr = addr_of(0);  s_axi_arlen = 8'd15;
      s_axi_awvalid = 1'b1; s_axi_awaddr = addr_of(48); s_axi_awlen = 8'd15;
      t = 0;
      while (!(s_axi_arready && s_axi_awready) && t < 50) begin @(negedge ap_clk); t++; end
      @(negedge ap_clk);
      s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
      s_axi_rready = 1'b1; s_axi_wvalid = 1'b1; s_axi_wstrb = '1;
      // Rewriting the model's own contents keeps memory predictable however many beats land
      for (int k = 0; k < 4; k++) begin s_axi_wdata = model[48 + k]; @(negedge ap_clk); end
      #2 areset = 1'b1;
      #1;
      compared++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
           err_wlast, err_range} !== 8'h00 || s_axi_rdata !== '0) begin
         mismatched++;
         $display("FAIL midburst_reset: flags %b rdata %h required all 0", {s_axi_awready, s_axi_wready,
                  s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, err_wlast, err_range}, s_axi_rdata);
      end
      s_axi_wvalid = 1'b0; s_axi_rready = 1'b1; s_axi_bready = 1'b1;
      repeat (2) @(negedge ap_clk);
      areset = 1'b0;
      spurious = 0;
      for (int k = 0; k < 8; k++) begin
         if (s_axi_rvalid || s_axi_bvalid) spurious++;
         @(negedge ap_clk);
      end
      s_axi_rready = 1'b0; s_axi_bready = 1'b0;
      compared++;
      if (spurious !== 0) begin mismatched++; $display("FAIL midburst_spurious: got %0d beats required 0", spurious); end
      do_read(addr_of(0), 15, 2, lat, unstable);
      for (int b = 0; b < 16; b++) begin
         compared++;
         if (b >= rd_q.size() || rd_q[b] !== exp_word(64'(b))) begin
            mismatched++; $display("FAIL post_reset_read[%0d]: got %h required %h", b, (b < rd_q.size()) ? rd_q[b] : '0, exp_word(64'(b)));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_basic_burst();
      test_partial_strobe();
      test_rready_toggle();
      test_wlast_err();
      test_range();
      test_random();
      test_back_to_back();
      test_reset_midburst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule

// File: doc/probatina_axi_mem_slave.md
Name: probatina_axi_mem_slave

Overview:
- AXI4 responder (slave) for the reduced master signal set driven by the probatina kernel's m00_axi port: AW/W/B/AR/R with addr, len, data, strb, last only; no id/size/burst/resp.
- Backs the port with an internal word-addressed memory so kernel RTL runs in simulation and loopback builds without a platform memory subsystem.
- Serves one write burst and one read burst concurrently; each channel handles one outstanding burst at a time.

Parameters:
- C_S_AXI_ADDR_WIDTH, 64, byte address width.
- C_S_AXI_DATA_WIDTH, 512, data width in bits; power of two, >= 32.
- C_MEM_DEPTH, 1024, memory depth in data words; power of two.
- C_BASE_ADDR, 0, byte address of word 0; aligned to C_S_AXI_DATA_WIDTH/8.

Ports:
- ap_clk  in  1  single clock; all logic is on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awvalid in 1; s_axi_awready out 1; s_axi_awaddr in ADDR_WIDTH; s_axi_awlen in 8  write address channel.
- s_axi_wvalid in 1; s_axi_wready out 1; s_axi_wdata in DATA_WIDTH; s_axi_wstrb in DATA_WIDTH/8; s_axi_wlast in 1  write data channel.
- s_axi_bvalid out 1; s_axi_bready in 1  write response channel.
- s_axi_arvalid in 1; s_axi_arready out 1; s_axi_araddr in ADDR_WIDTH; s_axi_arlen in 8  read address channel.
- s_axi_rvalid out 1; s_axi_rready in 1; s_axi_rdata out DATA_WIDTH; s_axi_rlast out 1  read data channel.
- err_wlast out 1  sticky flag: wlast did not match the beat count.
- err_range out 1  sticky flag: a beat addressed a location outside memory.

Behaviour:
- Reset (async assert, deassert synchronised to ap_clk inside the block):
  - Both FSMs go to IDLE.
  - All valid/ready outputs, rlast, err_wlast and err_range go to 0; rdata goes to 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; no B or R beats are emitted for it afterwards.
- Word index = (addr - C_BASE_ADDR) >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored. Bursts are INCR only; index increments by 1 per beat. The 4 KB boundary is not checked.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On an AW handshake, latch the index and beat count = awlen+1, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes whose wstrb bit is set; wstrb=0 writes nothing. On the final counted beat, go to W_RESP.
  - wlast=1 on a non-final beat, or wlast=0 on the final beat, sets err_wlast. The burst length comes from the count only.
  - W_RESP: bvalid=1, held until bready, then return to W_IDLE. bvalid rises the cycle after the last W handshake.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On an AR handshake, latch index and count. The next cycle rvalid=1 and rdata=mem[index] (registered from an async-read array).
  - R_DATA: rdata, rvalid and rlast stay stable while rvalid=1 and rready=0.
  - On an R handshake of a non-final beat, the next beat is loaded the following cycle, so throughput is 1 beat per cycle with rready held high.
  - rlast=1 only on beat awlen... i.e. beat arlen. After that beat's handshake, rvalid=0 and the FSM returns to R_IDLE.
  - Latency from AR handshake to first rvalid: 1 cycle.
- Same-cycle read load and write to the same word: the read returns the old data, and the write completes.
- Out-of-range index: the write is dropped; the read returns all zeros. Either case sets err_range.
- awlen=0 and arlen=0 are single-beat bursts. Beat count is 9 bits, so a 256-beat burst is handled.
- AW and AR handshakes are independent; simultaneous acceptance is allowed.

Decomposition:
- Package probatina_axi_mem_pkg holds:
  - wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - LP_BYTES_PER_WORD, LP_WORD_SHIFT = $clog2(LP_BYTES_PER_WORD), LP_IDX_WIDTH = $clog2(C_MEM_DEPTH).
- One sub-module, probatina_axi_mem_ram:
  - byte-enable write port;
  - asynchronous read port;
  - parameterised width and depth.
- Both FSMs and the address arithmetic stay in the top module.

Test Plan:
- Write 4 beats (awlen=3) at C_BASE_ADDR with data 0x11..,0x22..,0x33..,0x44.., wstrb all ones; read back with arlen=3 -> rdata matches in order, rlast on beat 3 only, and exactly 1 bvalid.
- Partial strobe: word = 0xFF.. then write 0x00.. with wstrb=0x...0001 -> read shows byte 0 = 0x00 and all other bytes 0xFF.
- rready toggling 1,0,0,1 during an 8-beat read -> no beat lost or duplicated; rdata stable while stalled.
- 2-beat write with wlast on beat 0 -> err_wlast=1, both beats written, one B response.
- Read at C_BASE_ADDR + C_MEM_DEPTH*bytes -> rdata all zeros, err_range=1. Write to the same address -> memory unchanged.
- areset asserted mid 16-beat read and mid write -> outputs at reset values within the same cycle; a new AR after release is accepted and returns correct data.
